// File: rtl/mem_port_arbiter.sv
// Three-way arbiter sharing a single-port, fixed-latency memory between datapath,
// fetch and loader; read data is steered back through a {valid,id} tag pipeline.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1,
    parameter int AGE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,

    input  logic              x_req,
    input  logic              x_we,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    output logic              x_gnt,
    output logic              x_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ID_NONE = 2'd0,
        ID_D    = 2'd1,
        ID_F    = 2'd2,
        ID_X    = 2'd3
    } reqId_t;

    localparam logic [3:0] AGE_LIM  = 4'(AGE_MAX);
    localparam int         TAG_BITS = MEM_LAT * 3;

    logic [3:0]               fAge;
    logic [3:0]               xAge;
    logic                     fAged;
    logic                     xAged;
    reqId_t                   winner;
    logic                     readGrant;
    logic [2:0]               newTag;
    logic [MEM_LAT-1:0][2:0]  tagPipe;
    logic [2:0]               lastTag;
    logic                     retValid;
    reqId_t                   retId;

    assign fAged = (fAge == AGE_LIM);
    assign xAged = (xAge == AGE_LIM);

    // Holding reset low suppresses every grant, which also zeroes the memory drive.
    always_comb begin
        winner = ID_NONE;
        if (reset) begin
            if (f_req && fAged)      winner = ID_F;
            else if (x_req && xAged) winner = ID_X;
            else if (d_req)          winner = ID_D;
            else if (f_req)          winner = ID_F;
            else if (x_req)          winner = ID_X;
        end
    end

    assign d_gnt = (winner == ID_D);
    assign f_gnt = (winner == ID_F);
    assign x_gnt = (winner == ID_X);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (winner)
            ID_D: begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            ID_F: begin
                mem_en    = 1'b1;
                mem_addr  = f_addr;
            end
            ID_X: begin
                mem_en    = 1'b1;
                mem_we    = x_we;
                mem_addr  = x_addr;
                mem_wdata = x_wdata;
            end
            default: ;
        endcase
    end

    assign readGrant = mem_en && !mem_we;
    assign newTag    = {readGrant, winner};

    always_ff @(posedge clk) begin
        if (!reset) begin
            fAge    <= '0;
            xAge    <= '0;
            tagPipe <= '0;
        end else begin
            if (!f_req || f_gnt) fAge <= '0;
            else if (!fAged)     fAge <= fAge + 4'd1;

            if (!x_req || x_gnt) xAge <= '0;
            else if (!xAged)     xAge <= xAge + 4'd1;

            // Shift by concatenating the new tag below and dropping the oldest stage.
            tagPipe <= TAG_BITS'({tagPipe, newTag});
        end
    end

    assign lastTag  = tagPipe[MEM_LAT-1];
    assign retValid = lastTag[2] && reset;
    assign retId    = reqId_t'(lastTag[1:0]);

    assign d_rvalid = retValid && (retId == ID_D);
    assign f_rvalid = retValid && (retId == ID_F);
    assign x_rvalid = retValid && (retId == ID_X);
    assign rdata    = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares Tron's single-port memory between three requesters: datapath load/store (`d_*`), instruction fetch (`f_*`) and the external debug/program loader (`x_*`). One transaction is accepted per cycle. Reads are pipelined against a fixed-latency memory, and read data is routed back to the issuing requester through a tag pipeline. Arbitration is fixed priority with an aging guard so that fetch and the loader cannot be starved.

## Interface
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 16: data width.
- `MEM_LAT`, default 1: memory read latency in cycles; legal range 1..4.
- `AGE_MAX`, default 4: wait cycles before a low-priority requester is promoted; legal range 1..15.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `d_req` in 1: datapath request.
- `d_we` in 1: datapath write enable.
- `d_addr` in `ADDR_W`: datapath address.
- `d_wdata` in `DATA_W`: datapath write data.
- `d_gnt` out 1: datapath request accepted this cycle.
- `d_rvalid` out 1: datapath read data is valid on `rdata`.
- `f_req` in 1: fetch request (read-only).
- `f_addr` in `ADDR_W`: fetch address.
- `f_gnt` out 1: fetch request accepted.
- `f_rvalid` out 1: fetch read data valid.
- `x_req` in 1: loader request.
- `x_we` in 1: loader write enable.
- `x_addr` in `ADDR_W`: loader address.
- `x_wdata` in `DATA_W`: loader write data.
- `x_gnt` out 1: loader request accepted.
- `x_rvalid` out 1: loader read data valid.
- `rdata` out `DATA_W`: returned read data, qualified by the `*_rvalid` signals.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_rdata` in `DATA_W`: memory read data, valid `MEM_LAT` cycles after `mem_en` with `mem_we`=0.

## Operation
- **Request rule.** A requester holds `req`, `addr`, `we` and `wdata` stable until it sees its `gnt`. Dropping `req` before `gnt` withdraws the request.
- **Arbitration.** Combinational, once per cycle, with at most one `gnt` high. Priority order:
  1. aged fetch
  2. aged loader
  3. datapath
  4. fetch
  5. loader
- **Aging counters.** Separate counters `f_age` and `x_age`, 4 bits each.
  - Increment each cycle that the requester's `req`=1 and it is not granted.
  - Saturate at `AGE_MAX`.
  - Clear to 0 on its `gnt` or when its `req`=0.
  - The requester is "aged" when its counter equals `AGE_MAX`.
- **Memory drive on grant.** In the same cycle as `gnt`:
  - `mem_en`=1.
  - `mem_addr`, `mem_we` and `mem_wdata` are taken from the winner.
  - Fetch always drives `mem_we`=0.
- **Memory drive with no grant.** `mem_en`=0, `mem_we`=0, and `mem_addr`/`mem_wdata` are 0.
- **Writes** complete at `gnt`. They produce no `rvalid`.
- **Tag pipeline.** `MEM_LAT` stages; each stage holds {valid, 2-bit id}.
  - Stage 0 loads {1, winner id} on a read grant, otherwise {0, x}.
  - Stages shift every cycle.
- **Read return.** When the last stage is valid, the matching `*_rvalid`=1. `rdata` = `mem_rdata` combinationally in all cycles.
- **Back-to-back reads.** Fully pipelined; a new read may be granted every cycle regardless of in-flight reads.
- **Reset** (`reset`=0 at a clock edge):
  - All tag stages are invalidated and both age counters cleared.
  - While `reset`=0, all `gnt`, `rvalid`, `mem_en` and `mem_we` are forced 0.
  - Reads in flight at reset never produce `rvalid`, including their data returning after reset is released.

## Timing
- **Reset values:** all `*_gnt`=0, `*_rvalid`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=`mem_rdata` (don't-care).
- **Grant latency:** 0 cycles; `gnt` is in the same cycle as `req` when that requester wins.
- **Read latency:** a read granted in cycle N produces `rvalid` in cycle N+`MEM_LAT`.
- **Worst-case wait for fetch or loader:** `AGE_MAX` cycles.
  - Both aged in the same cycle: fetch wins. The loader stays aged and wins next cycle unless fetch re-ages first.
  - With `AGE_MAX`≥2 the loader is therefore granted within `AGE_MAX`+1 cycles.
- **Request dropped at the grant cycle:** the winner is computed from `req` as sampled combinationally. A `req` that is low in a cycle is never granted in that cycle.
- **Simultaneous grant and read return:** a grant in cycle N and an `rvalid` for an older read in cycle N are independent. Both are asserted, for the same or different requesters.

## Test plan
- **Fetch read, `MEM_LAT`=2.** `f_req`=1, `f_addr`=0x0010 in cycle 0 → `f_gnt`=1, `mem_en`=1, `mem_addr`=0x0010, `mem_we`=0 in cycle 0. In cycle 2, `f_rvalid`=1 and `rdata` = memory word at 0x0010 (e.g. 0xBEEF); no other `rvalid`.
- **Three-way contention.** `d_req`, `f_req` and `x_req` all high in cycle 0 → `d_gnt` only, `mem_addr`=`d_addr`. With `d_req` low in cycle 1 → `f_gnt` in cycle 1.
- **Aging, `AGE_MAX`=4.** `d_req` held high every cycle, `f_req` high from cycle 0 → `d_gnt` in cycles 0-3 and `f_gnt` in cycle 4. The counter then clears and fetch next wins at cycle 9 if still requesting.
- **Write.** `d_req`=1, `d_we`=1, `d_addr`=0x0100, `d_wdata`=0x1234 → same cycle `mem_we`=1, `mem_wdata`=0x1234, `d_gnt`=1. No `d_rvalid` in any later cycle.
- **Pipelined reads, `MEM_LAT`=3.** Fetch reads granted in cycles 0, 1 and 2 at 0x0000/0x0001/0x0002 → `f_rvalid` in cycles 3, 4 and 5 with the matching data.
- **Reset mid-flight, `MEM_LAT`=2.** Read granted in cycle 0, `reset`=0 in cycle 1 and released in cycle 2 → no `rvalid` in cycles 1-4. All outputs are 0 while `reset`=0.
